// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter
//   Shift-register sequencer that runs as a one-hot ring counter (period WIDTH)
//   or a twisted-ring/Johnson counter (period 2*WIDTH), chosen at run time.
//   Illegal states, whether loaded or caused by an upset, are replaced by the
//   seed of the active mode and flagged.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   en       in   advance enable (hold when low)
//   mode     in   0 = ring (one-hot), 1 = Johnson
//   dir      in   0 = shift toward LSB, 1 = shift toward MSB
//   load     in   parallel load strobe
//   load_val in   [WIDTH-1:0] value to load
//   ring     out  [WIDTH-1:0] registered counter state
//   wrap     out  one-cycle pulse: an advance returned the state to seed
//   err      out  one-cycle pulse: illegal state loaded/detected and reseeded
module ring_johnson_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] ring,
    output logic             wrap,
    output logic             err
);

    // Mode the current ring contents belong to; a mismatch with the mode
    // input forces a reseed before anything else happens.
    logic             mode_q;

    logic [WIDTH-1:0] ring_d;
    logic [WIDTH-1:0] adv;
    logic             mode_d;
    logic             wrap_d;
    logic             err_d;
    logic             cur_legal;
    logic             ld_legal;

    // Ring seed is the MSB alone; Johnson seed is all zeros.
    function automatic logic [WIDTH-1:0] seed_of(input logic m);
        logic [WIDTH-1:0] s;
        s = '0;
        if (!m) s[WIDTH-1] = 1'b1;
        return s;
    endfunction

    // Ring: exactly one bit set. Johnson: at most one boundary between
    // adjacent bits (no wrap-around comparison), which gives 2*WIDTH patterns.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
        int unsigned ones;
        int unsigned flips;
        ones  = 0;
        flips = 0;
        for (int i = 0; i < WIDTH; i++) ones += 32'(v[i]);
        for (int i = 0; i < WIDTH - 1; i++) flips += 32'(v[i] ^ v[i+1]);
        return m ? (flips <= 1) : (ones == 1);
    endfunction

    // Bit shifted in is the bit shifted out, inverted in Johnson mode.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v,
                                                 input logic m, input logic d);
        if (d) return {v[WIDTH-2:0], v[WIDTH-1] ^ m};
        else   return {v[0] ^ m, v[WIDTH-1:1]};
    endfunction

    assign cur_legal = is_legal(ring, mode_q);
    assign ld_legal  = is_legal(load_val, mode_q);
    assign adv       = advance(ring, mode_q, dir);

    always_comb begin
        ring_d = ring;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode != mode_q) begin
            ring_d = seed_of(mode);
            mode_d = mode;
        end else if (load) begin
            if (ld_legal) begin
                ring_d = load_val;
            end else begin
                ring_d = seed_of(mode_q);
                err_d  = 1'b1;
            end
        end else if (en) begin
            if (!cur_legal) begin
                // Corrupted state: recover to seed instead of advancing.
                ring_d = seed_of(mode_q);
                err_d  = 1'b1;
            end else begin
                ring_d = adv;
                wrap_d = (adv == seed_of(mode_q));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring   <= seed_of(mode);
            mode_q <= mode;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ring   <= ring_d;
            mode_q <= mode_d;
            wrap   <= wrap_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_johnson_counter.sv
// tb_ring_johnson_counter
//   Vector table for WIDTH=4 driven through a scoreboard queue, plus
//   parameter-sweep instances (WIDTH=2,5,8) monitored for legality and period.
module tb_ring_johnson_counter;

    logic       clk = 1'b0;
    logic       reset, en, mode, dir, load;
    logic [3:0] load_val;
    logic [3:0] ring;
    logic       wrap, err;
    logic       sw_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ring_johnson_counter #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .ring(ring), .wrap(wrap), .err(err)
    );

    // Sweep instances share the control inputs; load stays low during sweeps.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int W = (gi == 0) ? 2 : (gi == 1) ? 5 : 8;
        logic [W-1:0] lv = '0;
        logic [W-1:0] r;
        logic         w, e;
        int bad, wraps, per, last, cyc, seedbad;

        ring_johnson_counter #(.WIDTH(W)) u (
            .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
            .load(load), .load_val(lv), .ring(r), .wrap(w), .err(e)
        );

        initial begin
            logic [W-1:0] sd;
            int trans;
            bad = 0; wraps = 0; per = -1; last = 0; cyc = 0; seedbad = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    bad = 0; wraps = 0; per = -1; last = 0; cyc = 0; seedbad = 0;
                end else if (sw_on) begin
                    cyc++;
                    trans = 0;
                    for (int i = 0; i < W - 1; i++) if (r[i] != r[i+1]) trans++;
                    if (mode ? (trans > 1) : ($countones(r) != 1)) bad++;
                    if (e) bad++;
                    sd = '0;
                    if (!mode) sd[W-1] = 1'b1;
                    if (w) begin
                        wraps++;
                        per  = cyc - last;
                        last = cyc;
                        if (r != sd) seedbad++;
                    end
                end
            end
        end
    end

    typedef struct {
        logic       rst, en, mode, dir, load;
        logic [3:0] lv;
        logic [3:0] ring;
        logic       wrap, err;
        string      name;
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];

    task automatic add(input logic r_, en_, m_, d_, l_, input logic [3:0] lv_,
                       input logic [3:0] q_, input logic w_, e_, input string nm);
        vec_t v;
        v.rst = r_; v.en = en_; v.mode = m_; v.dir = d_; v.load = l_; v.lv = lv_;
        v.ring = q_; v.wrap = w_; v.err = e_; v.name = nm;
        tv.push_back(v);
    endtask

    task automatic check_sweep(input int w_, input int m_, input int bad_,
                               input int wraps_, input int per_, input int seedbad_);
        int p;
        p = m_ ? 2 * w_ : w_;
        n_cmp++;
        if (bad_ != 0) begin
            n_bad++;
            $display("FAIL sweep_legal W=%0d mode=%0d illegal_or_err=%0d expected 0", w_, m_, bad_);
        end
        n_cmp++;
        if (per_ != p) begin
            n_bad++;
            $display("FAIL sweep_period W=%0d mode=%0d period=%0d expected %0d", w_, m_, per_, p);
        end
        n_cmp++;
        if (wraps_ != 40 / p) begin
            n_bad++;
            $display("FAIL sweep_wraps W=%0d mode=%0d wraps=%0d expected %0d", w_, m_, wraps_, 40 / p);
        end
        n_cmp++;
        if (seedbad_ != 0) begin
            n_bad++;
            $display("FAIL sweep_wrap_seed W=%0d mode=%0d nonseed_wraps=%0d expected 0", w_, m_, seedbad_);
        end
    endtask

    initial begin
        vec_t v, x;
        reset = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;

        //  rst en md dr ld lv       ring     wr er
        add(1, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, "reset_ring");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, "ring_r1");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, "ring_r2");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, "ring_r3");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 0, "ring_wrap");
        add(0, 0, 0, 1, 0, 4'b0000, 4'b1000, 0, 0, "hold1");
        add(0, 0, 0, 1, 0, 4'b0000, 4'b1000, 0, 0, "hold2");
        add(0, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, "hold3");
        add(0, 1, 0, 0, 1, 4'b0010, 4'b0010, 0, 0, "load_ring_en");
        add(0, 1, 0, 1, 0, 4'b0000, 4'b0100, 0, 0, "ring_left");
        add(0, 1, 0, 0, 1, 4'b0110, 4'b1000, 0, 1, "load_ring_bad");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 0, 0, "err_cleared");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 0, 0, "ring_r2b");
        add(0, 1, 1, 0, 1, 4'b1111, 4'b0000, 0, 0, "mode_over_load");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, "js_r1");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1100, 0, 0, "js_r2");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1110, 0, 0, "js_r3");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1111, 0, 0, "js_r4");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0111, 0, 0, "js_r5");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0011, 0, 0, "js_r6");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, "js_r7");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, "js_wrap_r");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b0001, 0, 0, "js_l1");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b0011, 0, 0, "js_l2");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b0111, 0, 0, "js_l3");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1111, 0, 0, "js_l4");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1110, 0, 0, "js_l5");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1100, 0, 0, "js_l6");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b1000, 0, 0, "js_l7");
        add(0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, "js_wrap_l");
        add(0, 0, 1, 0, 1, 4'b0101, 4'b0000, 0, 1, "load_js_bad");
        add(0, 0, 1, 0, 1, 4'b0111, 4'b0111, 0, 0, "load_js_ok");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0011, 0, 0, "js_after_load");
        add(0, 0, 1, 0, 0, 4'b0000, 4'b0011, 0, 0, "js_hold");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, "js_a");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 0, "js_b_wrap");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, "js_c");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1100, 0, 0, "js_d");
        add(1, 1, 0, 0, 1, 4'b0001, 4'b1000, 0, 0, "reset_mid_load");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, "toggle1");
        add(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, "toggle2");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, "toggle3");
        add(0, 1, 1, 0, 0, 4'b0000, 4'b1000, 0, 0, "after_toggle");

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            v = tv[i];
            reset = v.rst; en = v.en; mode = v.mode; dir = v.dir;
            load = v.load; load_val = v.lv;
            sb.push_back(v);
            @(posedge clk);
            #1;
            x = sb.pop_front();
            n_cmp++;
            if (ring !== x.ring || wrap !== x.wrap || err !== x.err) begin
                n_bad++;
                $display("FAIL %s [%0d] got ring=%b wrap=%b err=%b expected ring=%b wrap=%b err=%b",
                         x.name, i, ring, wrap, err, x.ring, x.wrap, x.err);
            end
        end

        // Parameter sweep: 40 advances from reset per mode/direction.
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 2; d++) begin
                @(negedge clk); #1;
                reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0;
                mode = m[0]; dir = d[0];
                @(negedge clk); #1;
                reset = 1'b0; en = 1'b1; sw_on = 1'b1;
                repeat (40) @(posedge clk);
                @(negedge clk); #1;
                sw_on = 1'b0; en = 1'b0;
                check_sweep(2, m, g_sw[0].bad, g_sw[0].wraps, g_sw[0].per, g_sw[0].seedbad);
                check_sweep(5, m, g_sw[1].bad, g_sw[1].wraps, g_sw[1].per, g_sw[1].seedbad);
                check_sweep(8, m, g_sw[2].bad, g_sw[2].wraps, g_sw[2].per, g_sw[2].seedbad);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
